// File: rtl/envelope_bank_pkg.sv
// Shared types for the time-multiplexed ADSR envelope bank.
package env_pkg;

  localparam int CFG_W = 28;
  localparam int DIV_W = 7;

  typedef struct packed {
    logic [6:0] attack;
    logic [6:0] decay;
    logic [6:0] sustain;
    logic [6:0] rel;
  } env_config_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_phase_t;

  // Ticks-per-step minus one for the ramping phases; flat phases never consult it.
  function automatic logic [DIV_W-1:0] phase_rate(env_phase_t ph, env_config_t cfg);
    case (ph)
      ATTACK:  return cfg.attack;
      DECAY:   return cfg.decay;
      RELEASE: return cfg.rel;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/envelope_amp.sv
// Combinational ADSR amplitude for one channel, computed from its pre-update state.
module envelope_amp
  import env_pkg::*;
#(
  parameter int AMP_W  = 8,
  parameter int STEP_W = 8
) (
  input  env_phase_t        phase,
  input  logic [STEP_W-1:0] step,
  input  logic [AMP_W-1:0]  start,
  input  logic [AMP_W-1:0]  sus,
  output logic [AMP_W-1:0]  amp
);

  localparam int PROD_W = AMP_W + STEP_W;
  localparam logic [AMP_W-1:0] MAX = '1;

  logic [AMP_W-1:0] span;
  logic [AMP_W-1:0] delta;

  always_comb begin
    span = '0;
    case (phase)
      ATTACK:  span = MAX - start;
      DECAY:   span = MAX - sus;
      RELEASE: span = start;
      default: span = '0;
    endcase
  end

  // span*step < 2^PROD_W, so the shifted product always fits in AMP_W bits.
  assign delta = AMP_W'((PROD_W'(span) * PROD_W'(step)) >> STEP_W);

  always_comb begin
    amp = '0;
    case (phase)
      ATTACK:  amp = start + delta;
      DECAY:   amp = MAX - delta;
      SUSTAIN: amp = sus;
      RELEASE: amp = start - delta;
      default: amp = '0;
    endcase
  end

endmodule

// File: rtl/envelope_bank.sv
// Round-robin ADSR envelope generator: one shared datapath, per-channel state and config.
//
// phase   | meaning
// IDLE    | silent, waiting for the gate
// ATTACK  | ramp from start up to full scale
// DECAY   | ramp from full scale down to the sustain level
// SUSTAIN | hold the sustain level while the gate is held
// RELEASE | ramp from start down to zero after the gate drops
module envelope_bank
  import env_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int AMP_W    = 8,
  parameter int STEP_W   = 8,
  parameter int PRESCALE = 16,
  parameter int LEGATO   = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         note_on,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_channel,
  input  logic [CFG_W-1:0]            cfg_data,
  output logic                        amp_valid,
  output logic [$clog2(CHANNELS)-1:0] amp_channel,
  output logic [AMP_W-1:0]            amp_data,
  output logic                        done
);

  localparam int SLOT_W = $clog2(CHANNELS);
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
  localparam logic [PRE_W-1:0]  LAST_PRE  = PRE_W'(PRESCALE - 1);

  typedef struct packed {
    env_phase_t        phase;
    logic [STEP_W-1:0] step;
    logic [DIV_W-1:0]  div;
    logic [AMP_W-1:0]  start;
  } env_state_t;

  env_state_t  st_mem  [CHANNELS];
  env_config_t cfg_mem [CHANNELS];

  logic [SLOT_W-1:0] slot;
  logic [PRE_W-1:0]  prescaler;
  logic              tick;
  env_state_t        cur;
  env_state_t        nxt;
  env_config_t       cfg;
  logic              gate;
  logic [AMP_W-1:0]  sus_exp;
  logic [AMP_W-1:0]  amp;
  logic [DIV_W-1:0]  rate;
  logic              rel_end;

  assign tick    = (prescaler == LAST_PRE);
  assign cur     = st_mem[slot];
  assign cfg     = cfg_mem[slot];
  assign gate    = note_on[slot];
  assign sus_exp = {cfg.sustain, cfg.sustain[6 -: AMP_W-7]};
  assign rate    = phase_rate(cur.phase, cfg);

  always_ff @(posedge clock) begin
    if (reset) begin
      slot      <= '0;
      prescaler <= '0;
    end else begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      if (slot == LAST_SLOT) prescaler <= tick ? '0 : prescaler + 1'b1;
    end
  end

  // The slot reads its config before this edge's write lands, so a same-slot write applies next sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) cfg_mem[i] <= '0;
    end else if (cfg_we) begin
      cfg_mem[cfg_channel] <= cfg_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++)
        st_mem[i] <= '{phase: IDLE, step: '0, div: '0, start: '0};
    end else begin
      st_mem[slot] <= nxt;
    end
  end

  envelope_amp #(
    .AMP_W  (AMP_W),
    .STEP_W (STEP_W)
  ) u_amp (
    .phase (cur.phase),
    .step  (cur.step),
    .start (cur.start),
    .sus   (sus_exp),
    .amp   (amp)
  );

  always_comb begin
    nxt = cur;
    if (gate && (cur.phase == IDLE || cur.phase == RELEASE)) begin
      nxt.phase = ATTACK;
      nxt.step  = '0;
      nxt.div   = '0;
      nxt.start = (LEGATO != 0 && cur.phase == RELEASE) ? amp : '0;
    end else if (!gate && (cur.phase == ATTACK || cur.phase == DECAY || cur.phase == SUSTAIN)) begin
      nxt.phase = RELEASE;
      nxt.step  = '0;
      nxt.div   = '0;
      nxt.start = amp;
    end else if (tick && (cur.phase == ATTACK || cur.phase == DECAY || cur.phase == RELEASE)) begin
      if (cur.div == rate) begin
        nxt.div = '0;
        if (&cur.step) begin
          nxt.step = '0;
          case (cur.phase)
            ATTACK:  nxt.phase = DECAY;
            DECAY:   nxt.phase = SUSTAIN;
            default: nxt.phase = IDLE;
          endcase
        end else begin
          nxt.step = cur.step + 1'b1;
        end
      end else begin
        nxt.div = cur.div + 1'b1;
      end
    end
  end

  always_comb begin
    rel_end = (cur.phase == RELEASE) && (nxt.phase == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amp_valid   <= 1'b0;
      amp_channel <= '0;
      amp_data    <= '0;
      done        <= 1'b0;
    end else begin
      amp_valid   <= 1'b1;
      amp_channel <= slot;
      amp_data    <= amp;
      done        <= rel_end;
    end
  end

endmodule
